// File: rtl/instr_decode_stage.sv
// Instruction decode stage: field extraction, register scoreboard,
// SYN/HALT sequencing and a registered valid/ready output slot.
module instr_decode_stage #(
    parameter int INSTR_W = 16,
    parameter int REG_AW = 3,
    localparam int IMM_W = INSTR_W - 5 - REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_halt,
    output logic              out_alu_op,
    output logic              out_reg_wr_en,
    output logic              out_mem_wr_en,
    output logic              out_branch,
    output logic              out_fft_wr_en,
    output logic              out_set_en,
    output logic              out_syn,
    output logic              out_use_imm,
    output logic              out_set_freq,
    output logic [1:0]        out_shift_dist,
    output logic [REG_AW-1:0] out_reg1,
    output logic [REG_AW-1:0] out_reg2,
    output logic [IMM_W-1:0]  out_imm,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              sync_ack,
    input  logic              resume,
    output logic              illegal_op,
    output logic              halted
);

    localparam int NREG = 2 ** REG_AW;

    typedef enum logic [1:0] {RUN, WAIT_SYN, HALTED} state_t;

    typedef struct packed {
        logic              halt;
        logic              alu_op;
        logic              reg_wr_en;
        logic              mem_wr_en;
        logic              branch;
        logic              fft_wr_en;
        logic              set_en;
        logic              syn;
        logic              use_imm;
        logic              set_freq;
        logic [1:0]        shift_dist;
        logic [REG_AW-1:0] reg1;
        logic [REG_AW-1:0] reg2;
        logic [IMM_W-1:0]  imm;
    } dec_t;

    state_t            state;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_next;
    dec_t              d;
    dec_t              q;
    logic              legal;
    logic              src1;
    logic              src2;
    logic              hazard;
    logic              accept;
    logic [4:0]        opcode;
    logic [REG_AW-1:0] f_reg1;
    logic [REG_AW-1:0] f_reg2;
    logic [IMM_W-1:0]  f_imm;

    assign opcode = in_instr[INSTR_W-1 -: 5];
    assign f_reg1 = in_instr[INSTR_W-6 -: REG_AW];
    assign f_reg2 = in_instr[INSTR_W-6-REG_AW -: REG_AW];
    assign f_imm  = in_instr[IMM_W-1:0];

    always_comb begin
        d     = '0;
        legal = 1'b1;
        src1  = 1'b0;
        src2  = 1'b0;
        unique case (1'b1)
            opcode == 5'b00000: d.halt = 1'b1;
            opcode[4:2] == 3'b001: begin
                d.reg_wr_en  = 1'b1;
                d.use_imm    = 1'b1;
                d.shift_dist = opcode[1:0];
                d.reg1       = f_reg1;
                d.imm        = f_imm;
                src1         = 1'b1;
            end
            opcode == 5'b01000: begin
                d.fft_wr_en = 1'b1;
                d.reg1      = f_reg1;
                d.reg2      = f_reg2;
                src1        = 1'b1;
                src2        = 1'b1;
            end
            opcode == 5'b01001: begin
                d.mem_wr_en = 1'b1;
                d.reg1      = f_reg1;
                d.reg2      = f_reg2;
                src1        = 1'b1;
                src2        = 1'b1;
            end
            opcode == 5'b01010: begin
                d.alu_op    = 1'b1;
                d.reg_wr_en = 1'b1;
                d.reg1      = f_reg1;
                d.reg2      = f_reg2;
                src1        = 1'b1;
                src2        = 1'b1;
            end
            opcode == 5'b01011: d.branch = 1'b1;
            opcode == 5'b01100: begin
                d.set_freq = 1'b1;
                d.reg1     = f_reg1;
                d.reg2     = f_reg2;
                src1       = 1'b1;
                src2       = 1'b1;
            end
            opcode == 5'b01101: begin
                d.reg1 = f_reg1;
                src1   = 1'b1;
            end
            opcode == 5'b01110: d.set_en = 1'b1;
            opcode == 5'b01111: d.syn = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Hazard looks only at the registered scoreboard, never at this cycle's writeback.
    assign hazard = in_valid
                  & ((src1 & pending[f_reg1]) | (src2 & pending[f_reg2]));
    assign in_ready = rst_n & (state == RUN)
                    & (~out_valid | out_ready) & ~hazard;
    assign accept = in_valid & in_ready;

    always_comb begin
        pending_next = pending;
        if (wb_valid)
            pending_next[wb_addr] = 1'b0;
        if (accept && d.reg_wr_en)
            pending_next[d.reg1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            pending    <= '0;
            out_valid  <= 1'b0;
            q          <= '0;
            illegal_op <= 1'b0;
            halted     <= 1'b0;
        end else begin
            pending    <= pending_next;
            illegal_op <= accept & ~legal;
            if (accept && legal) begin
                out_valid <= 1'b1;
                q         <= d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                RUN: begin
                    if (accept && d.syn) begin
                        state <= WAIT_SYN;
                    end else if (accept && d.halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                WAIT_SYN: if (sync_ack) state <= RUN;
                HALTED: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign out_halt       = q.halt;
    assign out_alu_op     = q.alu_op;
    assign out_reg_wr_en  = q.reg_wr_en;
    assign out_mem_wr_en  = q.mem_wr_en;
    assign out_branch     = q.branch;
    assign out_fft_wr_en  = q.fft_wr_en;
    assign out_set_en     = q.set_en;
    assign out_syn        = q.syn;
    assign out_use_imm    = q.use_imm;
    assign out_set_freq   = q.set_freq;
    assign out_shift_dist = q.shift_dist;
    assign out_reg1       = q.reg1;
    assign out_reg2       = q.reg2;
    assign out_imm        = q.imm;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: hazards, stalls, SYN/HALT,
// illegal opcodes, reset and a wide-parameter instance.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_instr;
    logic        out_valid, out_ready;
    logic        o_halt, o_alu, o_rwr, o_mwr, o_br, o_fft;
    logic        o_sen, o_syn, o_uimm, o_sfq;
    logic [1:0]  o_sh;
    logic [2:0]  o_r1, o_r2;
    logic [7:0]  o_imm;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic        sync_ack, resume, illegal_op, halted;

    logic        v2, rdy2, ov2;
    logic [23:0] instr2;
    logic        p_halt, p_alu, p_rwr, p_mwr, p_br, p_fft;
    logic        p_sen, p_syn, p_uimm, p_sfq, p_ill, p_hlt;
    logic [1:0]  p_sh;
    logic [3:0]  p_r1, p_r2;
    logic [14:0] p_imm;
    logic [3:0]  wb_addr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_decode_stage u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_halt(o_halt), .out_alu_op(o_alu), .out_reg_wr_en(o_rwr),
        .out_mem_wr_en(o_mwr), .out_branch(o_br), .out_fft_wr_en(o_fft),
        .out_set_en(o_sen), .out_syn(o_syn), .out_use_imm(o_uimm),
        .out_set_freq(o_sfq), .out_shift_dist(o_sh),
        .out_reg1(o_r1), .out_reg2(o_r2), .out_imm(o_imm),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .sync_ack(sync_ack), .resume(resume),
        .illegal_op(illegal_op), .halted(halted)
    );

    instr_decode_stage #(.INSTR_W(24), .REG_AW(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v2), .in_ready(rdy2), .in_instr(instr2),
        .out_valid(ov2), .out_ready(1'b1),
        .out_halt(p_halt), .out_alu_op(p_alu), .out_reg_wr_en(p_rwr),
        .out_mem_wr_en(p_mwr), .out_branch(p_br), .out_fft_wr_en(p_fft),
        .out_set_en(p_sen), .out_syn(p_syn), .out_use_imm(p_uimm),
        .out_set_freq(p_sfq), .out_shift_dist(p_sh),
        .out_reg1(p_r1), .out_reg2(p_r2), .out_imm(p_imm),
        .wb_valid(1'b0), .wb_addr(wb_addr2),
        .sync_ack(1'b0), .resume(1'b0),
        .illegal_op(p_ill), .halted(p_hlt)
    );

    function automatic logic [15:0] enc(input logic [4:0] op,
                                        input logic [2:0] r1,
                                        input logic [2:0] r2);
        return {op, r1, r2, 5'b00000};
    endfunction

    function automatic logic [15:0] enci(input logic [4:0] op,
                                         input logic [2:0] r1,
                                         input logic [7:0] imm);
        return {op, r1, imm};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_instr = enc(5'b01010, 3'd2, 3'd3);
        out_ready = 1'b0;
        wb_valid = 1'b0;
        wb_addr = '0;
        sync_ack = 1'b0;
        resume = 1'b0;
        v2 = 1'b0;
        instr2 = '0;
        wb_addr2 = '0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_reg1", o_r1, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal_op, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // INCC r2,r3 then SR1 r2 must wait for writeback
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = enc(5'b01010, 3'd2, 3'd3);
        #1 chk("incc_ready", in_ready, 1);
        tick();
        chk("incc_valid", out_valid, 1);
        chk("incc_alu", o_alu, 1);
        chk("incc_rwr", o_rwr, 1);
        chk("incc_r1", o_r1, 2);
        chk("incc_r2", o_r2, 3);
        in_instr = enci(5'b00101, 3'd2, 8'h5A);
        #1 chk("haz_ready", in_ready, 0);
        tick();
        chk("haz_ready2", in_ready, 0);
        chk("haz_drain", out_valid, 0);
        wb_valid = 1'b1;
        wb_addr = 3'd2;
        #1 chk("haz_wb_same", in_ready, 0);
        tick();
        wb_valid = 1'b0;
        #1 chk("haz_clear", in_ready, 1);
        tick();
        chk("sr_valid", out_valid, 1);
        chk("sr_uimm", o_uimm, 1);
        chk("sr_shift", o_sh, 1);
        chk("sr_r1", o_r1, 2);
        chk("sr_r2", o_r2, 0);
        chk("sr_imm", o_imm, 8'h5A);

        // LDE/STE streaming, then a 3-cycle output stall
        in_instr = enc(5'b01000, 3'd1, 3'd4);
        tick();
        chk("lde_fft", o_fft, 1);
        chk("lde_r2", o_r2, 4);
        in_instr = enc(5'b01001, 3'd5, 3'd6);
        tick();
        chk("ste_mwr", o_mwr, 1);
        chk("ste_fft", o_fft, 0);
        chk("ste_r1", o_r1, 5);
        in_instr = enc(5'b01000, 3'd1, 3'd4);
        tick();
        chk("lde2_fft", o_fft, 1);
        out_ready = 1'b0;
        in_instr = enc(5'b01001, 3'd5, 3'd6);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", in_ready, 0);
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_r1", o_r1, 1);
            chk("stall_r2", o_r2, 4);
            chk("stall_mwr", o_mwr, 0);
        end
        out_ready = 1'b1;
        #1 chk("unstall_ready", in_ready, 1);
        tick();
        chk("ste2_mwr", o_mwr, 1);
        chk("ste2_r1", o_r1, 5);

        // SYN blocks until sync_ack
        in_instr = enc(5'b01111, 3'd0, 3'd0);
        tick();
        chk("syn_out", o_syn, 1);
        chk("syn_valid", out_valid, 1);
        in_instr = enc(5'b01011, 3'd0, 3'd0);
        for (int i = 0; i < 2; i++) begin
            #1 chk("syn_block", in_ready, 0);
            tick();
        end
        sync_ack = 1'b1;
        #1 chk("syn_ack_same", in_ready, 0);
        tick();
        sync_ack = 1'b0;
        #1 chk("syn_release", in_ready, 1);
        tick();
        chk("bp_branch", o_br, 1);
        chk("bp_valid", out_valid, 1);

        // HALT blocks until resume
        in_instr = 16'h0000;
        tick();
        chk("halt_flag", halted, 1);
        chk("halt_out", o_halt, 1);
        in_instr = enc(5'b01110, 3'd0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            #1 chk("halt_block", in_ready, 0);
            tick();
        end
        chk("halt_hold", halted, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_halted", halted, 0);
        #1 chk("resume_ready", in_ready, 1);
        tick();
        chk("sme_set_en", o_sen, 1);

        // Undefined opcode
        in_instr = enc(5'b10101, 3'd7, 3'd7);
        tick();
        chk("ill_pulse", illegal_op, 1);
        chk("ill_noissue", out_valid, 0);
        chk("ill_fields", o_sen, 1);
        in_valid = 1'b0;
        tick();
        chk("ill_oneshot", illegal_op, 0);

        // Reset while in WAIT_SYN with r5 pending
        in_valid = 1'b1;
        in_instr = enci(5'b00110, 3'd5, 8'h33);
        tick();
        chk("sr2_shift", o_sh, 2);
        in_instr = enc(5'b01111, 3'd0, 3'd0);
        #1 chk("syn2_ready", in_ready, 1);
        tick();
        chk("syn2_out", o_syn, 1);
        rst_n = 1'b0;
        in_instr = enci(5'b00101, 3'd5, 8'h11);
        #1 chk("rst2_ready", in_ready, 0);
        tick();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_syn", o_syn, 0);
        chk("rst2_r1", o_r1, 0);
        chk("rst2_imm", o_imm, 0);
        chk("rst2_halted", halted, 0);
        chk("rst2_illegal", illegal_op, 0);
        rst_n = 1'b1;
        #1 chk("rst2_run", in_ready, 1);
        tick();
        chk("rst2_accept", out_valid, 1);
        chk("rst2_acc_r1", o_r1, 5);
        in_valid = 1'b0;

        // Wide instance: 24-bit instructions, 16 registers
        v2 = 1'b1;
        instr2 = {5'b01010, 4'd15, 4'd9, 11'd0};
        tick();
        chk("w_valid", ov2, 1);
        chk("w_alu", p_alu, 1);
        chk("w_r1", p_r1, 15);
        chk("w_r2", p_r2, 9);
        instr2 = {5'b00111, 4'd3, 15'h5ABC};
        tick();
        chk("w_imm", p_imm, 15'h5ABC);
        chk("w_shift", p_sh, 3);
        chk("w_r2_zero", p_r2, 0);
        v2 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width in bits; legal range 16..32.
REQ-002 Parameter REG_AW, default 3, register-address width; register file holds 2**REG_AW entries.
REQ-003 Derived IMM_W = INSTR_W-5-REG_AW, immediate width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake; transfer when both high.
REQ-007 in_instr  in  INSTR_W  instruction word; opcode = in_instr[INSTR_W-1:INSTR_W-5].
REQ-008 out_valid / out_ready  out / in  1 / 1  execute-side handshake; issue when both high.
REQ-009 out_halt, out_alu_op, out_reg_wr_en, out_mem_wr_en, out_branch, out_fft_wr_en, out_set_en, out_syn, out_use_imm, out_set_freq  out  1 each  registered decode flags.
REQ-010 out_shift_dist  out  2; out_reg1, out_reg2  out  REG_AW each; out_imm  out  IMM_W.
REQ-011 wb_valid / wb_addr  in  1 / REG_AW  register writeback completion, clears a pending write.
REQ-012 sync_ack  in  1  releases a SYN wait; resume  in  1  leaves HALTED.
REQ-013 illegal_op  out  1  one-cycle pulse on accepting an undefined opcode; halted  out  1  high in HALTED.

Function
REQ-014 Fields: reg1 = in_instr[INSTR_W-6 -: REG_AW]; reg2 = next REG_AW bits down; imm = in_instr[IMM_W-1:0]; shift_dist = opcode[1:0].
REQ-015 Opcode map; flags not listed are 0 and unused register fields are driven 0:
 - 00000 HALT: halt.
 - 001xx SR0-3: reg_wr_en, use_imm, shift_dist, reg1, imm.
 - 01000 LDE: fft_wr_en, reg1, reg2. 01001 STE: mem_wr_en, reg1, reg2.
 - 01010 INCC: alu_op, reg_wr_en, reg1, reg2. 01011 BP: branch.
 - 01100 SFC: set_freq, reg1, reg2. 01101 SPM: reg1. 01110 SME: set_en. 01111 SYN: syn.
REQ-016 Any other opcode is accepted, is not issued (out_valid unchanged by it), and pulses illegal_op the following cycle.
REQ-017 Latency: an instruction accepted in cycle N has its decoded fields valid on outputs with out_valid=1 in cycle N+1.
REQ-018 Output register holds all fields stable while out_valid=1 and out_ready=0.
REQ-019 out_valid clears after an issue with no new acceptance in the same cycle; issue and acceptance in the same cycle give full throughput.
REQ-020 Source registers: SR reads reg1; LDE, STE, INCC, SFC read reg1 and reg2; SPM reads reg1; all others read none.
REQ-021 Scoreboard pending[2**REG_AW]: bit reg1 sets when an instruction with reg_wr_en is accepted; bit wb_addr clears when wb_valid.
REQ-022 Same-cycle set and clear of the same bit: set wins.
REQ-023 hazard = in_valid and any source register of in_instr is pending; wb_valid clearing that bit in the same cycle does not remove the hazard (registered scoreboard only).
REQ-024 in_ready = (state==RUN) and (!out_valid or out_ready) and !hazard.
REQ-025 States: RUN, WAIT_SYN, HALTED.
REQ-026 RUN->WAIT_SYN on accepting SYN; WAIT_SYN->RUN on the first cycle sync_ack=1; sync_ack is ignored outside WAIT_SYN.
REQ-027 RUN->HALTED on accepting HALT; HALTED->RUN on resume=1; resume is ignored outside HALTED.
REQ-028 The SYN or HALT instruction itself still issues on the output; the state only blocks later acceptance.
REQ-029 Scoreboard clearing via wb_valid continues in every state.

Reset
REQ-030 rst_n=0 at a clock edge sets state=RUN, pending=0, out_valid=0, all out_* fields 0, illegal_op=0 and halted=0, regardless of any in-flight handshake or wait.
REQ-031 in_ready is 0 during any cycle with rst_n=0.

Verification
REQ-032 INCC r2,r3 accepted, then SR1 r2 presented with no writeback -> in_ready=0; wb_valid with wb_addr=2 -> SR1 accepted the next cycle.
REQ-033 Back-to-back LDE, STE with out_ready=1 -> one issue per cycle; with out_ready=0 for 3 cycles -> LDE fields held constant, STE not accepted.
REQ-034 SYN accepted -> out_syn=1 next cycle, in_ready=0 until sync_ack; sync_ack=1 -> next instruction accepted one cycle later.
REQ-035 HALT accepted -> halted=1, in_ready=0 for 10 cycles; resume pulse -> RUN, halted=0.
REQ-036 Opcode 10101 -> illegal_op pulse, no issue; rst_n=0 while in WAIT_SYN with pending[5]=1 -> all outputs 0, state RUN, pending cleared.
REQ-037 INSTR_W=24, REG_AW=4: INCC r15,r9 -> out_reg1=15, out_reg2=9, IMM_W=15.
